// File: rtl/cordic_rotation_seq.sv
// Rotation-mode CORDIC sequencer: x, y, z iteration registers plus the arctangent
// ROM, time-sharing one external combinational single-precision add/sub unit.
module cordic_rotation_seq #(
  parameter int ITER = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] x_in,
  input  logic [31:0] y_in,
  input  logic [31:0] z_in,
  output logic        busy,
  output logic        done,
  output logic [31:0] x_out,
  output logic [31:0] y_out,
  output logic [31:0] z_out,
  output logic [31:0] fpu_a,
  output logic [31:0] fpu_b,
  output logic        fpu_ctrl,
  input  logic [31:0] fpu_result
);

  typedef enum logic [2:0] {S_IDLE, S_OP_X, S_OP_Y, S_OP_Z, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] x_q, x_d, y_q, y_d, z_q, z_d, xt_q, xt_d;
  logic [4:0]  i_q, i_d;
  logic [31:0] cap;
  logic        d_neg, last_iter;

  // v * 2^-i by exponent adjustment; flushes to signed zero on underflow
  function automatic logic [31:0] sh(input logic [31:0] v, input logic [4:0] i);
    if (v[30:23] <= {3'b000, i}) return {v[31], 31'b0};
    return {v[31], v[30:23] - {3'b000, i}, v[22:0]};
  endfunction

  function automatic logic [31:0] atan_rom(input logic [4:0] i);
    case (i)
      5'd0:  return 32'h3F490FDB;
      5'd1:  return 32'h3EED6338;
      5'd2:  return 32'h3E7ADBB0;
      5'd3:  return 32'h3DFEADD5;
      5'd4:  return 32'h3D7FAADE;
      5'd5:  return 32'h3CFFEAAE;
      5'd6:  return 32'h3C7FFAAB;
      5'd7:  return 32'h3BFFFEAB;
      5'd8:  return 32'h3B7FFFAB;
      5'd9:  return 32'h3AFFFFEB;
      5'd10: return 32'h3A7FFFFB;
      5'd11: return 32'h39FFFFFF;
      5'd12: return 32'h39800000;
      5'd13: return 32'h39000000;
      5'd14: return 32'h38800000;
      5'd15: return 32'h38000000;
      5'd16: return 32'h37800000;
      5'd17: return 32'h37000000;
      5'd18: return 32'h36800000;
      5'd19: return 32'h36000000;
      5'd20: return 32'h35800000;
      5'd21: return 32'h35000000;
      5'd22: return 32'h34800000;
      5'd23: return 32'h34000000;
      default: return 32'h00000000;
    endcase
  endfunction

  // z is only written on the OP_Z edge, so its sign stays the direction
  // chosen at OP_X entry for the whole iteration.
  assign d_neg     = z_q[31];
  assign last_iter = (i_q == 5'(ITER - 1));

  always_comb begin
    fpu_a    = 32'h0;
    fpu_b    = 32'h0;
    fpu_ctrl = 1'b0;
    unique case (state_q)
      S_OP_X: begin fpu_a = x_q; fpu_b = sh(y_q, i_q); fpu_ctrl = ~d_neg; end
      S_OP_Y: begin fpu_a = y_q; fpu_b = sh(x_q, i_q); fpu_ctrl =  d_neg; end
      S_OP_Z: begin fpu_a = z_q; fpu_b = atan_rom(i_q); fpu_ctrl = ~d_neg; end
      default: ;
    endcase
  end

  // The add/sub unit always inserts the hidden 1, so zero operands are resolved here
  always_comb begin
    if (fpu_b[30:23] == 8'd0)      cap = fpu_a;
    else if (fpu_a[30:23] == 8'd0) cap = {fpu_b[31] ^ fpu_ctrl, fpu_b[30:0]};
    else                           cap = fpu_result;
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    xt_d    = xt_q;
    i_d     = i_q;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      S_IDLE: if (start) begin
        x_d     = x_in;
        y_d     = y_in;
        z_d     = z_in;
        i_d     = 5'd0;
        state_d = S_OP_X;
      end
      S_OP_X: begin
        busy    = 1'b1;
        xt_d    = cap;
        state_d = S_OP_Y;
      end
      S_OP_Y: begin
        busy    = 1'b1;
        y_d     = cap;
        x_d     = xt_q;
        state_d = S_OP_Z;
      end
      S_OP_Z: begin
        busy = 1'b1;
        z_d  = cap;
        if (last_iter) state_d = S_DONE;
        else begin
          i_d     = i_q + 5'd1;
          state_d = S_OP_X;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      x_q     <= 32'h0;
      y_q     <= 32'h0;
      z_q     <= 32'h0;
      xt_q    <= 32'h0;
      i_q     <= 5'd0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      xt_q    <= xt_d;
      i_q     <= i_d;
    end
  end

  assign x_out = x_q;
  assign y_out = y_q;
  assign z_out = z_q;

endmodule

// File: tb/tb_cordic_rotation_seq.sv
// Scoreboard bench: a real-arithmetic CORDIC reference predicts the add/sub port
// trace and the final registers; a negedge monitor pops and compares.
module tb_cordic_rotation_seq;
  localparam int ITER = 16;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [31:0] x_in, y_in, z_in;
  logic        busy, done, fpu_ctrl;
  logic [31:0] x_out, y_out, z_out, fpu_a, fpu_b, fpu_result;

  typedef struct {
    logic [31:0] x, y, z;
    int          done_cyc;
  } exp_t;

  typedef struct {
    logic [31:0] a, b;
    logic        c;
  } port_t;

  exp_t  exp_q[$];
  port_t trace_q[$];
  int    checks = 0, failures = 0, cyc = 0;

  cordic_rotation_seq #(.ITER(ITER)) dut (
    .clk(clk), .rst(rst), .start(start),
    .x_in(x_in), .y_in(y_in), .z_in(z_in),
    .busy(busy), .done(done),
    .x_out(x_out), .y_out(y_out), .z_out(z_out),
    .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_ctrl(fpu_ctrl),
    .fpu_result(fpu_result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic real s2r(input logic [31:0] v);
    logic [10:0] e11;
    if (v[30:23] == 8'd0) return v[31] ? -0.0 : 0.0;
    e11 = 11'(int'(v[30:23]) + 896);
    return $bitstoreal({v[31], e11, v[22:0], 29'b0});
  endfunction

  function automatic logic [31:0] r2s(input real r);
    logic [63:0] b;
    logic [24:0] m;
    int          e;
    b = $realtobits(r);
    if (b[62:52] == 11'd0) return {b[63], 31'b0};
    e = int'(b[62:52]) - 896;
    m = {2'b01, b[51:29]};
    if (b[28] && ((|b[27:0]) || m[0])) m = m + 25'd1;
    if (m[24]) begin m = m >> 1; e++; end
    if (e <= 0) return {b[63], 31'b0};
    if (e >= 255) return {b[63], 8'hFF, 23'b0};
    return {b[63], e[7:0], m[22:0]};
  endfunction

  function automatic logic [31:0] fadd(input logic [31:0] a, b, input logic sub);
    return r2s(sub ? s2r(a) - s2r(b) : s2r(a) + s2r(b));
  endfunction

  // External add/sub unit; a zero operand yields a poison NaN since the unit
  // cannot represent zero inputs meaningfully.
  always_comb begin
    if (fpu_a[30:23] == 8'd0 || fpu_b[30:23] == 8'd0) fpu_result = 32'h7FC00BAD;
    else fpu_result = fadd(fpu_a, fpu_b, fpu_ctrl);
  end

  function automatic real pow2n(input int i);
    real p = 1.0;
    repeat (i) p = p / 2.0;
    return p;
  endfunction

  function automatic logic [31:0] scale(input logic [31:0] v, input int i);
    if (int'(v[30:23]) <= i) return {v[31], 31'b0};
    return r2s(s2r(v) * pow2n(i));
  endfunction

  // Arithmetic seen through the zero rules of the sequencer
  function automatic logic [31:0] op(input logic [31:0] a, b, input logic sub);
    if (b[30:23] == 8'd0) return a;
    if (a[30:23] == 8'd0) return sub ? {~b[31], b[30:0]} : b;
    return fadd(a, b, sub);
  endfunction

  task automatic ref_model(input logic [31:0] x0, y0, z0, output exp_t e);
    logic [31:0] x = x0, y = y0, z = z0, xn, yn, at, sy, sx;
    logic        dpos;
    for (int i = 0; i < ITER; i++) begin
      dpos = ~z[31];
      sy = scale(y, i);
      sx = scale(x, i);
      at = r2s($atan(pow2n(i)));
      trace_q.push_back('{a: x, b: sy, c: dpos});
      trace_q.push_back('{a: y, b: sx, c: ~dpos});
      trace_q.push_back('{a: z, b: at, c: dpos});
      xn = op(x, sy, dpos);
      yn = op(y, sx, ~dpos);
      x = xn;
      y = yn;
      z = op(z, at, dpos);
    end
    e.x = x; e.y = y; e.z = z; e.done_cyc = 0;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  task automatic chk_near(input string nm, input real act, input real req, input real tol);
    checks++;
    if (!((act - req <= tol) && (req - act <= tol))) begin
      failures++;
      $display("FAIL %s: got %f expected %f", nm, act, req);
    end
  endtask

  always @(negedge clk) begin
    port_t p;
    exp_t  e;
    if (!rst) begin
      if (busy) begin
        if (trace_q.size() == 0) chk("unexpected_busy", 32'd1, 32'd0);
        else begin
          p = trace_q.pop_front();
          chk("fpu_a", fpu_a, p.a);
          chk("fpu_b", fpu_b, p.b);
          chk("fpu_ctrl", {31'b0, fpu_ctrl}, {31'b0, p.c});
        end
      end else if (!done) begin
        chk("idle_fpu_ports", {fpu_a ^ fpu_b, 31'b0} | {31'b0, fpu_ctrl} | fpu_a, 32'h0);
      end
      if (done) begin
        if (exp_q.size() == 0) chk("spurious_done", 32'd1, 32'd0);
        else begin
          e = exp_q.pop_front();
          chk("done_busy_low", {31'b0, busy}, 32'd0);
          chk("done_cycle", cyc, e.done_cyc);
          chk("x_out", x_out, e.x);
          chk("y_out", y_out, e.y);
          chk("z_out", z_out, e.z);
        end
      end
    end
  end

  task automatic start_run(input logic [31:0] x, y, z);
    exp_t e;
    ref_model(x, y, z, e);
    x_in = x; y_in = y; z_in = z;
    start = 1'b1;
    @(posedge clk); #1;
    e.done_cyc = cyc + 3 * ITER;
    exp_q.push_back(e);
    start = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 3 * ITER + 20);
    if (!done) chk("done_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic run(input logic [31:0] x, y, z);
    start_run(x, y, z);
    wait_done();
  endtask

  function automatic logic [31:0] rnd(input int span, input real div);
    return r2s(real'(int'($urandom_range(0, 2 * span)) - span) / div);
  endfunction

  task automatic chk_reset_outs(input string nm);
    chk({nm, "_busy"}, {31'b0, busy}, 32'd0);
    chk({nm, "_done"}, {31'b0, done}, 32'd0);
    chk({nm, "_x"}, x_out, 32'd0);
    chk({nm, "_y"}, y_out, 32'd0);
    chk({nm, "_z"}, z_out, 32'd0);
  endtask

  initial begin
    exp_t e1, e2;
    int   t0;
    rst = 1'b1; start = 1'b0; x_in = '0; y_in = '0; z_in = '0;
    repeat (3) @(posedge clk);
    #1 chk_reset_outs("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // rotate (1,0) by +/- pi/4
    run(32'h3F800000, 32'h0, 32'h3F490FDB);
    chk_near("pos_x", s2r(x_out), 1.164435, 1.2e-4);
    chk_near("pos_y", s2r(y_out), 1.164435, 1.2e-4);
    chk_near("pos_z", s2r(z_out), 0.0, 2e-5);
    run(32'h3F800000, 32'h0, 32'hBF490FDB);
    chk_near("neg_x", s2r(x_out), 1.164435, 1.2e-4);
    chk_near("neg_y", s2r(y_out), -1.164435, 1.2e-4);

    // scaling underflow of tiny operands and the zero-a bypass
    run(32'h3F800000, 32'h01C00000, 32'h3F000000);
    run(32'h01C00000, 32'h0, 32'h3F000000);
    run(32'h0, 32'h0, 32'h80000000);

    // start pulses while busy are ignored
    start_run(32'h3F800000, 32'h3F000000, 32'hBE800000);
    repeat (5) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (20) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done();
    repeat (4) @(posedge clk);
    #1;

    // reset mid-run abandons the run
    start_run(32'h3F800000, 32'h3F800000, 32'h3F000000);
    repeat (8) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    exp_q.delete();
    trace_q.delete();
    chk_reset_outs("midrun_rst");
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 run(32'h3FC00000, 32'hBF000000, 32'h3F4CCCCD);

    // start held high through DONE begins a second run from IDLE
    ref_model(32'h3F800000, 32'h3E800000, 32'hBFC00000, e1);
    ref_model(32'h3F800000, 32'h3E800000, 32'hBFC00000, e2);
    x_in = 32'h3F800000; y_in = 32'h3E800000; z_in = 32'hBFC00000;
    start = 1'b1;
    @(posedge clk); #1;
    t0 = cyc;
    e1.done_cyc = t0 + 3 * ITER;
    e2.done_cyc = t0 + 6 * ITER + 2;
    exp_q.push_back(e1);
    exp_q.push_back(e2);
    repeat (3 * ITER + 2) @(posedge clk);
    #1 start = 1'b0;
    wait_done();

    for (int k = 0; k < 20; k++)
      run(rnd(2000, 1000.0), rnd(2000, 1000.0), rnd(17000, 10000.0));

    repeat (3) @(posedge clk);
    chk("exp_queue_drained", exp_q.size(), 32'd0);
    chk("trace_queue_drained", trace_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
